// File: rtl/step_pulse_gen.sv
// Step/direction pulse generator for a stepper motor driver with direction setup time and period floor.
// Optional position counter compiled in with macro STEP_POS_COUNTER_EN.
module step_pulse_gen #(
    parameter int WIDTH_N    = 17,
    parameter int PULSE_W    = 50,
    parameter int DIR_SETUP  = 25,
    parameter int MIN_PERIOD = 100
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               drv_enable_SM,
    input  logic               dir_in,
    input  logic [WIDTH_N-1:0] N,
    input  logic               pos_clear,
    output logic               drv_step,
    output logic               drv_dir,
    output logic               busy,
    output logic [31:0]        position
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        HIGH  = 2'd2,
        LOW   = 2'd3
    } state_t;

    state_t      state_r;
    logic [31:0] cnt_r;
    logic [31:0] period_r;
    logic        drv_step_r;
    logic        drv_dir_r;
    logic        busy_r;

    logic [31:0] n_ext_s;
    logic [31:0] period_s;
    logic        start_s;
    logic        dir_chg_s;
    logic        decide_s;
    logic        enter_high_s;
    logic        go_setup_s;

    // Decision points: IDLE or the last LOW cycle re-evaluates the start condition.
    always_comb begin
        n_ext_s      = 32'(N);
        period_s     = (n_ext_s > 32'(MIN_PERIOD)) ? n_ext_s : 32'(MIN_PERIOD);
        start_s      = drv_enable_SM && (N != {WIDTH_N{1'b0}});
        dir_chg_s    = (dir_in != drv_dir_r);
        decide_s     = (state_r == IDLE) ||
                       ((state_r == LOW) && (cnt_r == period_r - 32'(PULSE_W) - 32'd1));
        go_setup_s   = decide_s && start_s && dir_chg_s;
        enter_high_s = (decide_s && start_s && !dir_chg_s) ||
                       ((state_r == SETUP) && (cnt_r == 32'(DIR_SETUP - 1)));
    end

    // Step FSM; outputs are registered alongside the state so drv_step tracks HIGH exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            cnt_r      <= 32'd0;
            period_r   <= 32'd0;
            drv_step_r <= 1'b0;
            drv_dir_r  <= 1'b0;
            busy_r     <= 1'b0;
        end else if (enter_high_s) begin
            state_r    <= HIGH;
            cnt_r      <= 32'd0;
            period_r   <= period_s;
            drv_step_r <= 1'b1;
            busy_r     <= 1'b1;
        end else if (go_setup_s) begin
            state_r    <= SETUP;
            cnt_r      <= 32'd0;
            drv_dir_r  <= dir_in;
            drv_step_r <= 1'b0;
            busy_r     <= 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    cnt_r <= 32'd0;
                end
                SETUP: begin
                    cnt_r <= cnt_r + 32'd1;
                end
                HIGH: begin
                    if (cnt_r == 32'(PULSE_W - 1)) begin
                        state_r    <= LOW;
                        cnt_r      <= 32'd0;
                        drv_step_r <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r + 32'd1;
                    end
                end
                LOW: begin
                    // decide_s already covers the last LOW cycle with a restart; here it means stop.
                    if (decide_s) begin
                        state_r <= IDLE;
                        cnt_r   <= 32'd0;
                        busy_r  <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r + 32'd1;
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    cnt_r      <= 32'd0;
                    drv_step_r <= 1'b0;
                    busy_r     <= 1'b0;
                end
            endcase
        end
    end

    assign drv_step = drv_step_r;
    assign drv_dir  = drv_dir_r;
    assign busy     = busy_r;

`ifdef STEP_POS_COUNTER_EN
    logic [31:0] position_r;

    // Position follows each step rise in the direction already on drv_dir; clear wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            position_r <= 32'd0;
        end else if (pos_clear) begin
            position_r <= 32'd0;
        end else if (enter_high_s) begin
            position_r <= drv_dir_r ? (position_r + 32'd1) : (position_r - 32'd1);
        end else begin
            position_r <= position_r;
        end
    end

    assign position = position_r;
`else
    logic pos_clear_unused_s;
    assign pos_clear_unused_s = pos_clear;
    assign position           = 32'd0;
`endif

endmodule

// File: doc/step_pulse_gen.md
STEP_PULSE_GEN -- requirements
Module: step_pulse_gen

Interface
REQ-001 Parameter WIDTH_N, default 17: width of the period input.
REQ-002 Parameter PULSE_W, default 50: drv_step high time, in clk cycles (1 us at 50 MHz).
REQ-003 Parameter DIR_SETUP, default 25: cycles between a drv_dir change and the next drv_step rise.
REQ-004 Parameter MIN_PERIOD, default 100: floor on the step period, in clk cycles; must exceed PULSE_W.
REQ-005 Port clk, input, 1: 50 MHz system clock; sole clock.
REQ-006 Port rst_n, input, 1: asynchronous active-low reset.
REQ-007 Port drv_enable_SM, input, 1: step enable from the tracking controller.
REQ-008 Port dir_in, input, 1: requested direction (1 = toward x0).
REQ-009 Port N, input, WIDTH_N: step period in clk cycles; 0 means no stepping.
REQ-010 Port pos_clear, input, 1: synchronous clear of the position counter.
REQ-011 Port drv_step, output, 1: registered step pulse to the motor driver.
REQ-012 Port drv_dir, output, 1: registered direction to the motor driver.
REQ-013 Port busy, output, 1: high whenever state is not IDLE.
REQ-014 Port position, output, 32: signed step count.

Function
REQ-015 FSM states: IDLE, SETUP, HIGH, LOW.
REQ-016 drv_step shall be 1 exactly in the cycles where the state is HIGH.
REQ-017 Start condition: in IDLE with drv_enable_SM=1 and N!=0.
- if dir_in!=drv_dir: drv_dir<=dir_in, go to SETUP.
- else: go to HIGH.
REQ-018 SETUP shall last exactly DIR_SETUP cycles, then go to HIGH.
REQ-019 On each transition into HIGH, the period shall be latched as max(N, MIN_PERIOD).
REQ-020 N changes shall never alter a step already in progress.
REQ-021 HIGH shall last PULSE_W cycles, then go to LOW.
REQ-022 LOW shall last (latched period − PULSE_W) cycles, so step-rise to step-rise spacing equals the latched period.
REQ-023 At the end of LOW, the FSM shall re-evaluate the REQ-017 start condition; if it fails, go to IDLE.
REQ-024 drv_enable_SM falling mid-step shall not truncate the pulse; the current HIGH/LOW completes, then IDLE.
REQ-025 N=0 mid-step shall not abort the current step; stepping stops at the end of LOW.
REQ-026 dir_in changing mid-step: drv_dir shall stay stable until the current LOW ends, then REQ-017 applies.
REQ-027 The first drv_step rise shall occur 1 cycle after the start condition is sampled (no direction change), or DIR_SETUP+1 cycles after (with a direction change).
REQ-028 The period counter shall be 32 bits wide and shall not wrap for any legal N.

Reset
REQ-029 With rst_n=0, outputs shall asynchronously become:
- state=IDLE, drv_step=0, drv_dir=0, busy=0, position=0.
- all counters cleared.
REQ-030 Reset asserted mid-pulse shall drop drv_step immediately.
REQ-031 After rst_n deasserts, the first start condition is evaluated on the first clk edge with rst_n=1.

Configuration
REQ-032 Macro STEP_POS_COUNTER_EN, when defined, shall compile in the position counter:
- position += 1 on each drv_step rise with drv_dir=1.
- position −= 1 on each drv_step rise with drv_dir=0.
- wraps modulo 2^32.
- pos_clear=1 forces 0 and takes priority over a simultaneous step.
REQ-033 Without STEP_POS_COUNTER_EN, position shall be tied to 0 and pos_clear ignored.

Verification
REQ-034 Steady stepping: N=1000, dir_in=0=drv_dir, enable held.
- drv_step rises every 1000 cycles, high 50 cycles.
- first rise 1 cycle after enable.
REQ-035 Period floor: N=40.
- steps spaced 100 cycles, high 50.
- changing N to 2000 mid-LOW leaves the current step at 100 cycles; the next step is 2000.
REQ-036 Direction change: dir_in 0→1 during LOW with N=500.
- drv_dir toggles when LOW ends.
- next drv_step rises 26 cycles later.
- (STEP_POS_COUNTER_EN) position counts down, then up.
REQ-037 Disable mid-pulse: drop drv_enable_SM at HIGH cycle 10, N=300.
- pulse still lasts 50 cycles.
- busy falls 300 cycles after that rise.
- no further steps.
REQ-038 Reset mid-pulse: rst_n=0 at HIGH cycle 5.
- drv_step=0 and position=0 before the next clk edge.
- restart after release per REQ-027.
REQ-039 Simultaneous pos_clear and step rise: position=0 (macro on); position stays 0 (macro off).
